cmos_capture: RTL and testbench



---
 rtl/cmos_capture_pkg.sv | 11 +
 rtl/fps_meter.sv | 37 +++
 rtl/cmos_capture.sv | 105 ++++++++++
 tb/tb_cmos_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cmos_capture_pkg.sv
// cmos_capture_pkg: shared state encoding and width helpers for the DVP capture block
//   SKIP   - discarding start-up frames
//   ACTIVE - capturing pixels
//   cnt_w(n) - bits needed to hold 0..n (X_W = cnt_w(H_DISP), Y_W = cnt_w(V_DISP), skip width = cnt_w(SKIP_FRAMES))
package cmos_capture_pkg;
    typedef enum logic {SKIP = 1'b0, ACTIVE = 1'b1} state_t;
    localparam int FPS_W = 8;
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/fps_meter.sv
// fps_meter: counts frame_done pulses per CLK_FREQ-cycle window, saturating at 255
//   clk, rst   - pixel clock, synchronous active-high reset
//   frame_done - one-cycle pulse per accepted frame
//   fps_rate   - frames seen in the last closed window, held between updates
module fps_meter
    import cmos_capture_pkg::*;
#(
    parameter int CLK_FREQ = 24_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_done,
    output logic [FPS_W-1:0] fps_rate
);
    localparam int W_W = cnt_w(CLK_FREQ - 1);
    localparam int TERM_I = CLK_FREQ - 1;
    localparam logic [W_W-1:0] TERM = TERM_I[W_W-1:0];
    logic [W_W-1:0] win;
    logic [FPS_W-1:0] cnt, cnt_nx;
    logic term;
    always_comb begin
        term = win == TERM;
        cnt_nx = (&cnt) ? cnt : cnt + {{(FPS_W-1){1'b0}}, frame_done};
    end
    // a frame_done on the terminal cycle belongs to the closing window
    always_ff @(posedge clk) begin
        if (rst) begin
            win <= '0;
            cnt <= '0;
            fps_rate <= '0;
        end else begin
            win <= term ? '0 : win + 1'b1;
            cnt <= term ? '0 : cnt_nx;
            if (term) fps_rate <= cnt_nx;
        end
    end
endmodule

// File: rtl/cmos_capture.sv
// cmos_capture: OV5640 DVP byte stream to clipped RGB565 pixel strobes with frame skip and geometry checks
//   clk, rst          - pixel clock (cmos_pclk), synchronous active-high reset
//   cmos_href/vsync   - line valid / frame sync (vsync rising edge is the frame boundary)
//   cmos_data         - DVP byte, high byte first
//   RGB_vld, RGB_data - one-cycle pixel strobe with {byte0, byte1}
//   frame_done        - pulse at the end of each accepted frame
//   geom_err          - sticky geometry error, cleared only by rst
//   FPS_rate          - frames per second; built only with CMOS_CAPTURE_FPS_EN, else 0
module cmos_capture
    import cmos_capture_pkg::*;
#(
    parameter int H_DISP      = 640,
    parameter int V_DISP      = 480,
    parameter int SKIP_FRAMES = 10,
    parameter int CLK_FREQ    = 24_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmos_href,
    input  logic             cmos_vsync,
    input  logic [7:0]       cmos_data,
    output logic             RGB_vld,
    output logic [15:0]      RGB_data,
    output logic             frame_done,
    output logic             geom_err,
    output logic [FPS_W-1:0] FPS_rate
);
    localparam int X_W = cnt_w(H_DISP);
    localparam int Y_W = cnt_w(V_DISP);
    localparam int S_W = cnt_w(SKIP_FRAMES);
    // one spare bit lets x/y saturate just past the limit so overruns stay visible
    localparam logic [X_W:0] H_LIM = H_DISP[X_W:0];
    localparam logic [Y_W:0] V_LIM = V_DISP[Y_W:0];
    localparam logic [S_W-1:0] SKIP_LIM = SKIP_FRAMES[S_W-1:0];
    state_t state, state_nx;
    logic [S_W-1:0] skip_cnt, skip_inc, skip_nx;
    logic href1, href2, vs1, vs2, phase, aborted;
    logic [7:0] d1, hi_byte;
    logic [X_W:0] x;
    logic [Y_W:0] y;
    logic vs_rise, abort_now, in_line, h_fall, pix, active, keep, err;
    always_comb begin
        vs_rise = vs1 & ~vs2;
        abort_now = vs_rise & href1;
        // an aborted line is ignored until href drops, so it neither pairs bytes nor counts a line
        in_line = href1 & ~aborted & ~vs_rise;
        h_fall = href2 & ~href1 & ~aborted;
        pix = in_line & phase;
        active = state == ACTIVE;
        keep = pix & active & (x < H_LIM) & (y < V_LIM);
        skip_inc = skip_cnt + 1'b1;
        skip_nx = (state == SKIP && vs_rise) ? skip_inc : skip_cnt;
        state_nx = (state == SKIP && vs_rise && skip_inc == SKIP_LIM) ? ACTIVE : state;
        err = active & ((h_fall & ((x != H_LIM) | phase)) | (vs_rise & (y != '0) & (y != V_LIM)) | abort_now);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= (SKIP_FRAMES == 0) ? ACTIVE : SKIP;
            skip_cnt <= '0;
            {href1, href2, vs1, vs2, phase, aborted} <= '0;
            d1 <= '0;
            hi_byte <= '0;
            x <= '0;
            y <= '0;
            RGB_vld <= 1'b0;
            RGB_data <= '0;
            frame_done <= 1'b0;
            geom_err <= 1'b0;
        end else begin
            state <= state_nx;
            skip_cnt <= skip_nx;
            href1 <= cmos_href;
            href2 <= href1;
            vs1 <= cmos_vsync;
            vs2 <= vs1;
            d1 <= cmos_data;
            aborted <= abort_now | (aborted & href1);
            phase <= in_line & ~phase;
            if (in_line & ~phase) hi_byte <= d1;
            RGB_vld <= keep;
            if (keep) RGB_data <= {hi_byte, d1};
            frame_done <= vs_rise & active & (y != '0);
            geom_err <= geom_err | err;
            if (vs_rise) begin
                x <= '0;
                y <= '0;
            end else if (h_fall) begin
                x <= '0;
                y <= (y > V_LIM) ? y : y + 1'b1;
            end else if (pix && x <= H_LIM) begin
                x <= x + 1'b1;
            end
        end
    end
`ifdef CMOS_CAPTURE_FPS_EN
    fps_meter #(.CLK_FREQ(CLK_FREQ)) u_fps (
        .clk(clk),
        .rst(rst),
        .frame_done(frame_done),
        .fps_rate(FPS_rate)
    );
`else
    assign FPS_rate = '0;
`endif
endmodule

// File: tb/tb_cmos_capture.sv
// tb_cmos_capture: directed, table-driven bench for cmos_capture (H_DISP=4, V_DISP=2, SKIP_FRAMES=2, CLK_FREQ=100)
module tb_cmos_capture;
    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] pix;
    } vec_t;
    logic clk = 1'b0;
    logic rst, cmos_href, cmos_vsync;
    logic [7:0] cmos_data;
    logic RGB_vld, frame_done, geom_err;
    logic [15:0] RGB_data;
    logic [7:0] FPS_rate;
    int checks = 0, errors = 0;
    int n_vld = 0, n_fd = 0, n_b2b = 0;
    logic vld_d = 1'b0;
    logic [15:0] got[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    cmos_capture #(.H_DISP(4), .V_DISP(2), .SKIP_FRAMES(2), .CLK_FREQ(100)) dut (
        .clk(clk),
        .rst(rst),
        .cmos_href(cmos_href),
        .cmos_vsync(cmos_vsync),
        .cmos_data(cmos_data),
        .RGB_vld(RGB_vld),
        .RGB_data(RGB_data),
        .frame_done(frame_done),
        .geom_err(geom_err),
        .FPS_rate(FPS_rate)
    );

    always @(negedge clk) begin
        if (RGB_vld) begin
            n_vld++;
            got.push_back(RGB_data);
        end
        if (RGB_vld && vld_d) n_b2b++;
        if (frame_done) n_fd++;
        vld_d = RGB_vld;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic h, input logic v, input logic [7:0] d);
        cmos_href = h;
        cmos_vsync = v;
        cmos_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic vs_pulse();
        cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic line_bytes(input int n, input logic [7:0] seed);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, seed + 8'(i));
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    // 20-cycle frame: vsync pulse then two 4-pixel lines from the table
    task automatic frame_tbl();
        vs_pulse();
        for (int l = 0; l < 2; l++) begin
            for (int p = 0; p < 4; p++) begin
                cyc(1'b1, 1'b0, tbl[l*4+p].b0);
                cyc(1'b1, 1'b0, tbl[l*4+p].b1);
            end
            cyc(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vld"}, 32'(RGB_vld), 0);
        chk({tag, "_data"}, 32'(RGB_data), 0);
        chk({tag, "_fd"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(geom_err), 0);
        chk({tag, "_fps"}, 32'(FPS_rate), 0);
    endtask

    initial begin
        int b, q, f;
        tbl[0] = '{8'hF8, 8'h1F, 16'hF81F};
        tbl[1] = '{8'h00, 8'h00, 16'h0000};
        tbl[2] = '{8'hFF, 8'hFF, 16'hFFFF};
        tbl[3] = '{8'h12, 8'h34, 16'h1234};
        tbl[4] = '{8'h07, 8'hE0, 16'h07E0};
        tbl[5] = '{8'hA5, 8'h5A, 16'hA55A};
        tbl[6] = '{8'h80, 8'h01, 16'h8001};
        tbl[7] = '{8'h3C, 8'hC3, 16'h3CC3};
        rst = 1'b1;
        cmos_href = 1'b0;
        cmos_vsync = 1'b0;
        cmos_data = 8'h00;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        b = n_vld;
        frame_tbl();
        idle(3);
        chk("skip_frame1_strobes", 32'(n_vld - b), 0);
        for (int k = 0; k < 2; k++) begin
            b = n_vld;
            q = got.size();
            frame_tbl();
            idle(3);
            chk("active_frame_strobes", 32'(n_vld - b), 8);
            for (int i = 0; i < 8; i++) chk("active_frame_pixel", 32'(got[q+i]), 32'(tbl[i].pix));
        end
        chk("skip_frame_done_count", 32'(n_fd), 1);
        chk("skip_geom_err", 32'(geom_err), 0);

        vs_pulse();
        cyc(1'b1, 1'b0, 8'hF8);
        cyc(1'b1, 1'b0, 8'h1F);
        chk("lat_plus1_vld", 32'(RGB_vld), 0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("lat_plus2_vld", 32'(RGB_vld), 1);
        chk("lat_plus2_data", 32'(RGB_data), 32'h0000F81F);
        cyc(1'b0, 1'b0, 8'h00);
        chk("lat_plus3_vld", 32'(RGB_vld), 0);
        idle(2);
        chk("short_line_geom_err", 32'(geom_err), 1);
        chk("pair_frame_done_count", 32'(n_fd), 2);

        do_reset();
        vs_pulse();
        vs_pulse();
        chk("clip_pre_geom_err", 32'(geom_err), 0);
        b = n_vld;
        line_bytes(12, 8'h40);
        idle(3);
        chk("clip_h_strobes", 32'(n_vld - b), 4);
        chk("clip_h_geom_err", 32'(geom_err), 1);
        b = n_vld;
        line_bytes(8, 8'h50);
        idle(3);
        chk("clip_line2_strobes", 32'(n_vld - b), 4);
        b = n_vld;
        line_bytes(8, 8'h60);
        idle(3);
        chk("clip_line3_strobes", 32'(n_vld - b), 0);

        do_reset();
        vs_pulse();
        vs_pulse();
        b = n_vld;
        q = got.size();
        line_bytes(7, 8'h10);
        idle(3);
        chk("odd_strobes", 32'(n_vld - b), 3);
        chk("odd_pix0", 32'(got[q]), 32'h1011);
        chk("odd_pix2", 32'(got[q+2]), 32'h1415);
        chk("odd_geom_err", 32'(geom_err), 1);
        b = n_vld;
        cyc(1'b1, 1'b0, 8'hA0);
        cyc(1'b1, 1'b0, 8'hA1);
        cyc(1'b1, 1'b1, 8'hA2);
        cyc(1'b1, 1'b0, 8'hA3);
        cyc(1'b1, 1'b0, 8'hA4);
        cyc(1'b0, 1'b0, 8'h00);
        idle(3);
        chk("abort_strobes", 32'(n_vld - b), 1);
        b = n_vld;
        q = got.size();
        line_bytes(8, 8'h20);
        line_bytes(8, 8'h30);
        idle(3);
        chk("post_abort_strobes", 32'(n_vld - b), 8);
        chk("post_abort_pix0", 32'(got[q]), 32'h2021);
        f = n_fd;
        vs_pulse();
        idle(3);
        chk("post_abort_frame_done", 32'(n_fd - f), 1);

        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        cyc(1'b1, 1'b0, 8'h03);
        rst = 1'b1;
        cyc(1'b1, 1'b0, 8'h04);
        chk_zero("mid_reset");
        rst = 1'b0;
        idle(2);
        b = n_vld;
        frame_tbl();
        idle(3);
        chk("reskip_frame1_strobes", 32'(n_vld - b), 0);
        b = n_vld;
        frame_tbl();
        idle(3);
        chk("reskip_frame2_strobes", 32'(n_vld - b), 8);

        do_reset();
        repeat (14) frame_tbl();
`ifdef CMOS_CAPTURE_FPS_EN
        chk("fps_rate", 32'(FPS_rate), 5);
`else
        chk("fps_rate_disabled", 32'(FPS_rate), 0);
`endif
        chk("vld_back_to_back", 32'(n_b2b), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
